// File: rtl/systolic_result_writer.sv
// Drain stage for the systolic array: snapshots the SIZE x SIZE result matrix
// on a rising array_done and streams it row-major as bytes over valid/ready.
module systolic_result_writer #(
   parameter int SIZE         = 4,
   parameter int RESULT_WIDTH = 32,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    array_done,
   input  logic [RESULT_WIDTH-1:0] result_data [0:SIZE-1][0:SIZE-1],
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic                    abort,
   input  logic                    clear_status,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [7:0]              mem_wdata,
   output logic                    busy,
   output logic                    write_done,
   output logic                    range_err,
   output logic                    overrun_err,
   output logic [15:0]             matrices_written,
   output logic [1:0]              dbg_state_o
);

   localparam int NELEM = SIZE * SIZE;
   localparam int IDX_W = $clog2(NELEM);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NELEM - 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SNAP   = 2'd1;
   localparam logic [1:0] ST_WRITE  = 2'd2;
   localparam logic [1:0] ST_FINISH = 2'd3;

   // Handshake: a byte transfers on any rising clk where mem_valid && mem_ready;
   // while mem_ready is low, mem_valid, mem_addr and mem_wdata hold steady.

   logic [1:0]            state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  done_q;
   logic                  seen_low_q;
   logic                  range_q, range_d;
   logic                  overrun_q, overrun_d;
   logic [15:0]           count_q, count_d;
   logic [7:0]            buf_q [0:NELEM-1];

   logic [7:0]            snap_bytes [0:NELEM-1];
   logic                  snap_over;
   logic                  rise;
   logic                  xfer;

   // A level already high out of reset must fall once before it can count as a rise.
   assign rise = array_done && !done_q && seen_low_q;
   assign xfer = (state_q == ST_WRITE) && mem_ready;

   always_comb begin
      snap_bytes = '{default: 8'h00};
      snap_over  = 1'b0;
      for (int r = 0; r < SIZE; r++) begin
         for (int c = 0; c < SIZE; c++) begin
            if ((result_data[r][c] >> 8) != '0) begin
               snap_bytes[r*SIZE + c] = 8'hFF;
               snap_over              = 1'b1;
            end else begin
               snap_bytes[r*SIZE + c] = result_data[r][c][7:0];
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      base_d    = base_q;
      range_d   = clear_status ? 1'b0 : range_q;
      overrun_d = clear_status ? 1'b0 : overrun_q;
      count_d   = clear_status ? 16'd0 : count_q;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               state_d = ST_SNAP;
               base_d  = base_addr;
               idx_d   = '0;
               if (snap_over) range_d = 1'b1;
            end
         end
         ST_SNAP: begin
            state_d = abort ? ST_IDLE : ST_WRITE;
         end
         ST_WRITE: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (xfer) begin
               if (idx_q == LAST_IDX) state_d = ST_FINISH;
               else                   idx_d   = idx_q + IDX_W'(1);
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            count_d = count_d + 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase
      if (rise && (state_q != ST_IDLE)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         base_q     <= '0;
         done_q     <= 1'b0;
         seen_low_q <= 1'b0;
         range_q    <= 1'b0;
         overrun_q  <= 1'b0;
         count_q    <= 16'd0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         done_q     <= array_done;
         seen_low_q <= seen_low_q | ~array_done;
         range_q    <= range_d;
         overrun_q  <= overrun_d;
         count_q    <= count_d;
      end
   end

   // Snapshot storage carries no reset; outputs are gated off outside WRITE.
   always_ff @(posedge clk) begin
      if ((state_q == ST_IDLE) && rise) buf_q <= snap_bytes;
   end

   assign mem_valid        = (state_q == ST_WRITE);
   assign mem_addr         = mem_valid ? (base_q + ADDR_WIDTH'(idx_q)) : '0;
   assign mem_wdata        = mem_valid ? buf_q[idx_q] : 8'h00;
   assign busy             = (state_q == ST_SNAP) || (state_q == ST_WRITE);
   assign write_done       = (state_q == ST_FINISH);
   assign range_err        = range_q;
   assign overrun_err      = overrun_q;
   assign matrices_written = count_q;
   assign dbg_state_o      = state_q;

endmodule
